// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection, load-use hazard detection
// and a saturating counter of load-use stall cycles.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_valid,
    input  logic [31:0]       ID_pc,
    input  logic [4:0]        ID_rs1,
    input  logic [4:0]        ID_rs2,
    input  logic [4:0]        ID_rd,
    input  logic              ID_use_rs1,
    input  logic              ID_use_rs2,
    input  logic [31:0]       ID_imm,
    input  logic [3:0]        ID_alu_op,
    input  logic              ID_alu_src,
    input  logic              ID_regwrite,
    input  logic              ID_memread,
    input  logic              ID_memwrite,
    input  logic [DATA_W-1:0] RF_rs1_data,
    input  logic [DATA_W-1:0] RF_rs2_data,
    input  logic              ID_hazard_rs1_data_enable,
    input  logic [DATA_W-1:0] ID_hazard_rs1_data,
    input  logic              ID_hazard_rs2_data_enable,
    input  logic [DATA_W-1:0] ID_hazard_rs2_data,
    input  logic [4:0]        EX_MEM_rd,
    input  logic              EX_MEM_memread,
    input  logic              EX_MEM_regwrite,
    input  logic              EX_flush,
    output logic              ID_EX_valid,
    output logic [31:0]       ID_EX_pc,
    output logic [DATA_W-1:0] ID_EX_rs1_data,
    output logic [DATA_W-1:0] ID_EX_rs2_data,
    output logic [31:0]       ID_EX_imm,
    output logic [4:0]        ID_EX_rd,
    output logic [3:0]        ID_EX_alu_op,
    output logic              ID_EX_alu_src,
    output logic              ID_EX_regwrite,
    output logic              ID_EX_memread,
    output logic              ID_EX_memwrite,
    output logic              ID_stall,
    output logic [31:0]       stall_count
);

    // x0 always reads zero, even if the forwarding network claims otherwise.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [4:0]        rs,
        input logic              fwd_en,
        input logic [DATA_W-1:0] fwd_data,
        input logic [DATA_W-1:0] rf_data
    );
        if (rs == 5'd0)
            return '0;
        else if (fwd_en)
            return fwd_data;
        else
            return rf_data;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    // A load still in EX or in MEM has not produced data the forwarders can supply.
    function automatic logic load_use(input logic use_s, input logic [4:0] rs);
        logic ex_hit;
        logic mem_hit;
        ex_hit  = ID_EX_valid && ID_EX_memread && (ID_EX_rd == rs);
        mem_hit = EX_MEM_memread && EX_MEM_regwrite && (EX_MEM_rd == rs);
        return ID_valid && use_s && (rs != 5'd0) && (ex_hit || mem_hit);
    endfunction

    logic [DATA_W-1:0] rs1_sel;
    logic [DATA_W-1:0] rs2_sel;
    logic              hazard;
    logic              bubble;

    always_comb begin
        rs1_sel  = sel_operand(ID_rs1, ID_hazard_rs1_data_enable, ID_hazard_rs1_data, RF_rs1_data);
        rs2_sel  = sel_operand(ID_rs2, ID_hazard_rs2_data_enable, ID_hazard_rs2_data, RF_rs2_data);
        hazard   = load_use(ID_use_rs1, ID_rs1) || load_use(ID_use_rs2, ID_rs2);
        ID_stall = hazard && !EX_flush;
        bubble   = EX_flush || ID_stall;
    end

    // ID -> EX boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_EX_valid    <= 1'b0;
            ID_EX_pc       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_alu_op   <= '0;
            ID_EX_alu_src  <= 1'b0;
            ID_EX_regwrite <= 1'b0;
            ID_EX_memread  <= 1'b0;
            ID_EX_memwrite <= 1'b0;
            stall_count    <= '0;
        end else begin
            if (bubble) begin
                ID_EX_valid    <= 1'b0;
                ID_EX_pc       <= '0;
                ID_EX_rs1_data <= '0;
                ID_EX_rs2_data <= '0;
                ID_EX_imm      <= '0;
                ID_EX_rd       <= '0;
                ID_EX_alu_op   <= '0;
                ID_EX_alu_src  <= 1'b0;
                ID_EX_regwrite <= 1'b0;
                ID_EX_memread  <= 1'b0;
                ID_EX_memwrite <= 1'b0;
            end else begin
                ID_EX_valid    <= ID_valid;
                ID_EX_pc       <= ID_pc;
                ID_EX_rs1_data <= rs1_sel;
                ID_EX_rs2_data <= rs2_sel;
                ID_EX_imm      <= ID_imm;
                ID_EX_rd       <= ID_rd;
                ID_EX_alu_op   <= ID_alu_op;
                ID_EX_alu_src  <= ID_alu_src;
                ID_EX_regwrite <= ID_valid && ID_regwrite;
                ID_EX_memread  <= ID_valid && ID_memread;
                ID_EX_memwrite <= ID_valid && ID_memwrite;
            end
            if (ID_stall)
                stall_count <= sat_inc(stall_count);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences for the
// two-cycle load-use stall and an asynchronous reset pulse.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_valid;
    logic [31:0] ID_pc;
    logic [4:0]  ID_rs1, ID_rs2, ID_rd;
    logic        ID_use_rs1, ID_use_rs2;
    logic [31:0] ID_imm;
    logic [3:0]  ID_alu_op;
    logic        ID_alu_src, ID_regwrite, ID_memread, ID_memwrite;
    logic [31:0] RF_rs1_data, RF_rs2_data;
    logic        ID_hazard_rs1_data_enable, ID_hazard_rs2_data_enable;
    logic [31:0] ID_hazard_rs1_data, ID_hazard_rs2_data;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_memread, EX_MEM_regwrite, EX_flush;
    logic        ID_EX_valid;
    logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rd;
    logic [3:0]  ID_EX_alu_op;
    logic        ID_EX_alu_src, ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite;
    logic        ID_stall;
    logic [31:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_imm(ID_imm),
        .ID_alu_op(ID_alu_op), .ID_alu_src(ID_alu_src), .ID_regwrite(ID_regwrite),
        .ID_memread(ID_memread), .ID_memwrite(ID_memwrite),
        .RF_rs1_data(RF_rs1_data), .RF_rs2_data(RF_rs2_data),
        .ID_hazard_rs1_data_enable(ID_hazard_rs1_data_enable), .ID_hazard_rs1_data(ID_hazard_rs1_data),
        .ID_hazard_rs2_data_enable(ID_hazard_rs2_data_enable), .ID_hazard_rs2_data(ID_hazard_rs2_data),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread), .EX_MEM_regwrite(EX_MEM_regwrite),
        .EX_flush(EX_flush),
        .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data),
        .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm), .ID_EX_rd(ID_EX_rd),
        .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_regwrite(ID_EX_regwrite),
        .ID_EX_memread(ID_EX_memread), .ID_EX_memwrite(ID_EX_memwrite),
        .ID_stall(ID_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2, rw, mr, mw;
        logic [31:0] rf1, rf2;
        logic        he1;
        logic [31:0] hd1;
        logic        he2;
        logic [31:0] hd2;
        logic [4:0]  exm_rd;
        logic        exm_mr, exm_rw, flush;
        logic        e_stall, e_valid;
        logic [31:0] e_rs1d, e_rs2d;
        logic        e_rw, e_mr, e_mw;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_valid = 1'b0; ID_pc = '0; ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0;
        ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0; ID_imm = '0; ID_alu_op = '0;
        ID_alu_src = 1'b0; ID_regwrite = 1'b0; ID_memread = 1'b0; ID_memwrite = 1'b0;
        RF_rs1_data = '0; RF_rs2_data = '0;
        ID_hazard_rs1_data_enable = 1'b0; ID_hazard_rs1_data = '0;
        ID_hazard_rs2_data_enable = 1'b0; ID_hazard_rs2_data = '0;
        EX_MEM_rd = '0; EX_MEM_memread = 1'b0; EX_MEM_regwrite = 1'b0; EX_flush = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(ID_EX_valid), 32'd0);
        chk({tag, "_pc"}, ID_EX_pc, 32'd0);
        chk({tag, "_rs1d"}, ID_EX_rs1_data, 32'd0);
        chk({tag, "_rs2d"}, ID_EX_rs2_data, 32'd0);
        chk({tag, "_imm"}, ID_EX_imm, 32'd0);
        chk({tag, "_rd"}, 32'(ID_EX_rd), 32'd0);
        chk({tag, "_ctrl"}, {26'd0, ID_EX_alu_op, ID_EX_alu_src, ID_EX_regwrite},
            32'd0);
        chk({tag, "_mem"}, {30'd0, ID_EX_memread, ID_EX_memwrite}, 32'd0);
        chk({tag, "_cnt"}, stall_count, 32'd0);
    endtask

    initial begin
        //       valid rs1    rs2    rd     u1    u2    rw    mr    mw    rf1          rf2          he1   hd1           he2   hd2          exrd   exmr  exrw  flush stall vld   rs1d         rs2d         rw    mr    mw    cnt
        vt[0]  = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11,      32'h22,      1'b0, 32'h0,        1'b0, 32'h0,       5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,      32'h22,      1'b1, 1'b0, 1'b0, 32'd0};
        vt[1]  = '{1'b1, 5'd0, 5'd7, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234,    32'h55,      1'b1, 32'hDEADBEEF, 1'b1, 32'hAA,      5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,       32'hAA,      1'b1, 1'b0, 1'b0, 32'd0};
        vt[2]  = '{1'b1, 5'd6, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h66,      32'h55,      1'b0, 32'hDEADBEEF, 1'b0, 32'hAA,      5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66,      32'h55,      1'b1, 1'b1, 1'b0, 32'd0};
        vt[3]  = '{1'b1, 5'd1, 5'd9, 5'd10,1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1,       32'h2,       1'b0, 32'h0,        1'b0, 32'h0,       5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,       32'h2,       1'b1, 1'b0, 1'b0, 32'd0};
        vt[4]  = '{1'b0, 5'd3, 5'd4, 5'd11,1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33,      32'h44,      1'b0, 32'h0,        1'b0, 32'h0,       5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33,      32'h44,      1'b0, 1'b0, 1'b0, 32'd0};
        vt[5]  = '{1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h7,       32'h9,       1'b0, 32'h0,        1'b0, 32'h0,       5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7,       32'h0,       1'b1, 1'b1, 1'b0, 32'd0};
        vt[6]  = '{1'b1, 5'd5, 5'd0, 5'd12,1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1,       32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 1'b0, 32'd0};
        vt[7]  = '{1'b1, 5'd1, 5'd8, 5'd13,1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5,       32'h6,       1'b0, 32'h0,        1'b0, 32'h0,       5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 1'b0, 32'd1};
        vt[8]  = '{1'b1, 5'd1, 5'd8, 5'd13,1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10,      32'h20,      1'b0, 32'h0,        1'b0, 32'h0,       5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,      32'h20,      1'b1, 1'b0, 1'b0, 32'd1};
        vt[9]  = '{1'b0, 5'd1, 5'd8, 5'd14,1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h30,      32'h40,      1'b0, 32'h0,        1'b0, 32'h0,       5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h30,      32'h40,      1'b0, 1'b0, 1'b0, 32'd1};
        vt[10] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h77,      32'h88,      1'b0, 32'h0,        1'b0, 32'h0,       5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,       32'h0,       1'b1, 1'b0, 1'b0, 32'd1};

        clear_inputs();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            logic [31:0] iv;
            logic [31:0] e_pc, e_imm;
            logic [4:0]  e_rd;
            logic [3:0]  e_op;
            logic        e_src;
            logic        issued;
            iv = 32'(i);
            ID_valid = vt[i].valid; ID_rs1 = vt[i].rs1; ID_rs2 = vt[i].rs2; ID_rd = vt[i].rd;
            ID_use_rs1 = vt[i].use1; ID_use_rs2 = vt[i].use2;
            ID_regwrite = vt[i].rw; ID_memread = vt[i].mr; ID_memwrite = vt[i].mw;
            ID_pc = 32'h100 + (iv << 2); ID_imm = 32'hA000 + iv;
            ID_alu_op = iv[3:0]; ID_alu_src = iv[0];
            RF_rs1_data = vt[i].rf1; RF_rs2_data = vt[i].rf2;
            ID_hazard_rs1_data_enable = vt[i].he1; ID_hazard_rs1_data = vt[i].hd1;
            ID_hazard_rs2_data_enable = vt[i].he2; ID_hazard_rs2_data = vt[i].hd2;
            EX_MEM_rd = vt[i].exm_rd; EX_MEM_memread = vt[i].exm_mr;
            EX_MEM_regwrite = vt[i].exm_rw; EX_flush = vt[i].flush;
            issued = !(vt[i].flush || vt[i].e_stall);
            e_pc  = issued ? ID_pc : 32'd0;
            e_imm = issued ? ID_imm : 32'd0;
            e_rd  = issued ? ID_rd : 5'd0;
            e_op  = issued ? ID_alu_op : 4'd0;
            e_src = issued ? ID_alu_src : 1'b0;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(ID_stall), 32'(vt[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(ID_EX_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_pc", i), ID_EX_pc, e_pc);
            chk($sformatf("v%0d_rs1d", i), ID_EX_rs1_data, vt[i].e_rs1d);
            chk($sformatf("v%0d_rs2d", i), ID_EX_rs2_data, vt[i].e_rs2d);
            chk($sformatf("v%0d_imm", i), ID_EX_imm, e_imm);
            chk($sformatf("v%0d_rd", i), 32'(ID_EX_rd), 32'(e_rd));
            chk($sformatf("v%0d_aluop", i), 32'(ID_EX_alu_op), 32'(e_op));
            chk($sformatf("v%0d_alusrc", i), 32'(ID_EX_alu_src), 32'(e_src));
            chk($sformatf("v%0d_rw", i), 32'(ID_EX_regwrite), 32'(vt[i].e_rw));
            chk($sformatf("v%0d_mr", i), 32'(ID_EX_memread), 32'(vt[i].e_mr));
            chk($sformatf("v%0d_mw", i), 32'(ID_EX_memwrite), 32'(vt[i].e_mw));
            chk($sformatf("v%0d_cnt", i), stall_count, vt[i].e_cnt);
        end

        // Load x5 enters EX, dependent add waits two cycles then issues with forwarded data.
        clear_inputs();
        ID_valid = 1'b1; ID_rd = 5'd5; ID_rs1 = 5'd2; ID_use_rs1 = 1'b1;
        ID_regwrite = 1'b1; ID_memread = 1'b1; ID_pc = 32'h200;
        @(posedge clk); #1;
        chk("lw_in_ex", {30'd0, ID_EX_valid, ID_EX_memread}, 32'd3);
        clear_inputs();
        ID_valid = 1'b1; ID_pc = 32'h204; ID_rs1 = 5'd5; ID_rs2 = 5'd3; ID_rd = 5'd6;
        ID_use_rs1 = 1'b1; ID_use_rs2 = 1'b1; ID_regwrite = 1'b1;
        RF_rs1_data = 32'h111; RF_rs2_data = 32'h333;
        #1 chk("lu_stall1", 32'(ID_stall), 32'd1);
        @(posedge clk); #1;
        chk("lu_bubble1", 32'(ID_EX_valid), 32'd0);
        EX_MEM_rd = 5'd5; EX_MEM_memread = 1'b1; EX_MEM_regwrite = 1'b1;
        #1 chk("lu_stall2", 32'(ID_stall), 32'd1);
        @(posedge clk); #1;
        chk("lu_bubble2", 32'(ID_EX_valid), 32'd0);
        EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b0; EX_MEM_regwrite = 1'b0;
        ID_hazard_rs1_data_enable = 1'b1; ID_hazard_rs1_data = 32'hCAFE;
        #1 chk("lu_stall3", 32'(ID_stall), 32'd0);
        @(posedge clk); #1;
        chk("lu_issue_valid", 32'(ID_EX_valid), 32'd1);
        chk("lu_issue_pc", ID_EX_pc, 32'h204);
        chk("lu_issue_rs1d", ID_EX_rs1_data, 32'hCAFE);
        chk("lu_issue_rs2d", ID_EX_rs2_data, 32'h333);
        chk("lu_cnt", stall_count, 32'd3);

        // Two more MEM-stage stalls bring the count to 5, then a valid issue.
        clear_inputs();
        ID_valid = 1'b1; ID_rs1 = 5'd8; ID_use_rs1 = 1'b1; ID_pc = 32'h300; ID_rd = 5'd1;
        EX_MEM_rd = 5'd8; EX_MEM_memread = 1'b1; EX_MEM_regwrite = 1'b1;
        repeat (2) @(posedge clk);
        #1 EX_MEM_memread = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(ID_EX_valid), 32'd1);
        chk("pre_rst_cnt", stall_count, 32'd5);

        // Asynchronous reset between edges; only the EX_MEM term can stall during reset.
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        EX_MEM_memread = 1'b1;
        #1 chk("rst_exmem_stall", 32'(ID_stall), 32'd1);
        @(posedge clk); #1;
        chk("rst_hold_valid", 32'(ID_EX_valid), 32'd0);
        chk("rst_hold_cnt", stall_count, 32'd0);
        #3 rst = 1'b0;
        clear_inputs();
        ID_valid = 1'b1; ID_pc = 32'h400; ID_rs1 = 5'd4; ID_use_rs1 = 1'b1;
        RF_rs1_data = 32'h4444; ID_rd = 5'd2; ID_regwrite = 1'b1;
        #1 chk("post_rst_valid_pre", 32'(ID_EX_valid), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(ID_EX_valid), 32'd1);
        chk("post_rst_pc", ID_EX_pc, 32'h400);
        chk("post_rst_rs1d", ID_EX_rs1_data, 32'h4444);
        chk("post_rst_cnt", stall_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
